// File: rtl/simd_pkg.sv
// Shared widths, types and opcodes for the SIMD lane sequencer and its datapath neighbours.
package simd_pkg;

   localparam int LANES  = 8;
   localparam int LANE_W = 16;
   localparam int OP_W   = 4;
   localparam int VEC_W  = LANES * LANE_W;
   localparam int CNT_W  = $clog2(LANES);

   typedef logic [LANE_W-1:0] lane_t;
   typedef logic [VEC_W-1:0]  vec_t;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } seq_state_t;

   typedef enum logic [OP_W-1:0] {
      ALU_ADD  = 4'h0,
      ALU_SUB  = 4'h1,
      ALU_AND  = 4'h2,
      ALU_OR   = 4'h3,
      ALU_XOR  = 4'h4,
      ALU_PASS = 4'h5
   } alu_op_t;

endpackage

// File: rtl/simd_lane_sequencer_if.sv
// Request, ALU-side and response signals of the lane sequencer.
// The slave modport is the sequencer's view; master is issue logic, ALU and consumer combined.
interface simd_lane_sequencer_if;

   logic                                 req_valid;
   logic                                 req_ready;
   logic [simd_pkg::OP_W-1:0]            req_op;
   logic                                 req_use_imm;
   logic [simd_pkg::LANE_W-1:0]          req_imm;
   logic [simd_pkg::VEC_W-1:0]           req_vec_a;
   logic [simd_pkg::VEC_W-1:0]           req_vec_b;

   logic [simd_pkg::OP_W-1:0]            alu_op;
   logic [simd_pkg::LANE_W-1:0]          alu_a;
   logic [simd_pkg::LANE_W-1:0]          alu_b_reg;
   logic [simd_pkg::LANE_W-1:0]          alu_imm;
   logic                                 alu_mux_sel;
   logic [simd_pkg::LANE_W-1:0]          alu_result;

   logic                                 rsp_valid;
   logic                                 rsp_ready;
   logic [simd_pkg::VEC_W-1:0]           rsp_vec;

   logic                                 busy;

   modport slave (
      input  req_valid, req_op, req_use_imm, req_imm, req_vec_a, req_vec_b,
      input  alu_result, rsp_ready,
      output req_ready, alu_op, alu_a, alu_b_reg, alu_imm, alu_mux_sel,
      output rsp_valid, rsp_vec, busy
   );

   modport master (
      output req_valid, req_op, req_use_imm, req_imm, req_vec_a, req_vec_b,
      output alu_result, rsp_ready,
      input  req_ready, alu_op, alu_a, alu_b_reg, alu_imm, alu_mux_sel,
      input  rsp_valid, rsp_vec, busy
   );

endinterface

// File: rtl/simd_lane_select.sv
// Combinational extraction of lane idx from a packed vector (lane 0 in the low bits).
module simd_lane_select
   import simd_pkg::*;
(
   input  vec_t             vec,
   input  logic [CNT_W-1:0] idx,
   output lane_t            lane
);

   // A compare-per-lane mux keeps every slice index constant and in range.
   always_comb begin
      lane = '0;
      for (int i = 0; i < LANES; i++) begin
         if (idx == CNT_W'(i)) begin
            lane = vec[i*LANE_W +: LANE_W];
         end
      end
   end

endmodule

// File: rtl/simd_lane_sequencer.sv
// Streams one latched vector op through the shared lane ALU, lane 0 first,
// and gathers the per-lane results into a single response vector.
module simd_lane_sequencer
   import simd_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   simd_lane_sequencer_if.slave  bus
);

   localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

   seq_state_t       state_q, state_d;
   logic [CNT_W-1:0] lane_cnt_q, lane_cnt_d;
   logic [OP_W-1:0]  op_q, op_d;
   logic             use_imm_q, use_imm_d;
   lane_t            imm_q, imm_d;
   vec_t             vec_a_q, vec_a_d;
   vec_t             vec_b_q, vec_b_d;
   vec_t             rsp_vec_q, rsp_vec_d;
   lane_t            lane_a, lane_b;

   simd_lane_select u_sel_a (
      .vec  (vec_a_q),
      .idx  (lane_cnt_q),
      .lane (lane_a)
   );

   simd_lane_select u_sel_b (
      .vec  (vec_b_q),
      .idx  (lane_cnt_q),
      .lane (lane_b)
   );

   always_comb begin
      state_d    = state_q;
      lane_cnt_d = lane_cnt_q;
      op_d       = op_q;
      use_imm_d  = use_imm_q;
      imm_d      = imm_q;
      vec_a_d    = vec_a_q;
      vec_b_d    = vec_b_q;
      rsp_vec_d  = rsp_vec_q;

      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               op_d       = bus.req_op;
               use_imm_d  = bus.req_use_imm;
               imm_d      = bus.req_imm;
               vec_a_d    = bus.req_vec_a;
               vec_b_d    = bus.req_vec_b;
               lane_cnt_d = '0;
               state_d    = RUN;
            end
         end
         RUN: begin
            for (int i = 0; i < LANES; i++) begin
               if (lane_cnt_q == CNT_W'(i)) begin
                  rsp_vec_d[i*LANE_W +: LANE_W] = bus.alu_result;
               end
            end
            // The counter parks on the last lane rather than wrapping.
            if (lane_cnt_q == LAST_LANE) begin
               state_d = DONE;
            end else begin
               lane_cnt_d = lane_cnt_q + 1'b1;
            end
         end
         DONE: begin
            if (bus.rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         lane_cnt_q <= '0;
         op_q       <= '0;
         use_imm_q  <= 1'b0;
         imm_q      <= '0;
         vec_a_q    <= '0;
         vec_b_q    <= '0;
         rsp_vec_q  <= '0;
      end else begin
         state_q    <= state_d;
         lane_cnt_q <= lane_cnt_d;
         op_q       <= op_d;
         use_imm_q  <= use_imm_d;
         imm_q      <= imm_d;
         vec_a_q    <= vec_a_d;
         vec_b_q    <= vec_b_d;
         rsp_vec_q  <= rsp_vec_d;
      end
   end

   // ALU-side outputs stay at zero outside RUN so the shared ALU sees no toggling.
   always_comb begin
      bus.req_ready   = (state_q == IDLE);
      bus.busy        = (state_q != IDLE);
      bus.rsp_valid   = (state_q == DONE);
      bus.rsp_vec     = rsp_vec_q;
      bus.alu_op      = '0;
      bus.alu_a       = '0;
      bus.alu_b_reg   = '0;
      bus.alu_imm     = '0;
      bus.alu_mux_sel = 1'b0;
      if (state_q == RUN) begin
         bus.alu_op      = op_q;
         bus.alu_a       = lane_a;
         bus.alu_b_reg   = lane_b;
         bus.alu_imm     = imm_q;
         bus.alu_mux_sel = use_imm_q;
      end
   end

endmodule

// File: tb/tb_simd_lane_sequencer.sv
// Directed bench for simd_lane_sequencer with a small behavioural ALU and operand mux.
module tb_simd_lane_sequencer;
   import simd_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   check_count = 0;
   int   error_count = 0;

   simd_lane_sequencer_if bus_if ();

   simd_lane_sequencer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   always #5 clk = ~clk;

   // Stand-in for the operand-B mux and the lane ALU.
   lane_t operand_b;
   always_comb begin
      operand_b = bus_if.alu_mux_sel ? bus_if.alu_imm : bus_if.alu_b_reg;
      case (bus_if.alu_op)
         ALU_ADD: bus_if.alu_result = bus_if.alu_a + operand_b;
         ALU_SUB: bus_if.alu_result = bus_if.alu_a - operand_b;
         ALU_XOR: bus_if.alu_result = bus_if.alu_a ^ operand_b;
         default: bus_if.alu_result = '0;
      endcase
   end

   localparam vec_t VEC_A_RAMP  = 128'h0008_0007_0006_0005_0004_0003_0002_0001;
   localparam vec_t VEC_B_0010  = {8{16'h0010}};
   localparam vec_t RSP_T2      = 128'h0018_0017_0016_0015_0014_0013_0012_0011;
   localparam vec_t VEC_A_4     = 128'h0800_0700_0600_0500_0400_0300_0200_0100;
   localparam vec_t RSP_T4      = 128'h0801_0701_0601_0501_0401_0301_0201_0101;
   localparam vec_t VEC_A_4B    = 128'h0080_0070_0060_0050_0040_0030_0020_0010;
   localparam vec_t RSP_T4B     = 128'h007F_006F_005F_004F_003F_002F_001F_000F;
   localparam vec_t VEC_A_6     = 128'h7000_6000_5000_4000_3000_2000_1000_0000;
   localparam vec_t RSP_T6      = 128'h7101_6101_5101_4101_3101_2101_1101_0101;

   task automatic checkOutput(input string tag, input logic [VEC_W-1:0] actual,
                              input logic [VEC_W-1:0] expected);
      check_count++;
      if (actual !== expected) begin
         error_count++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [OP_W-1:0] op, input logic use_imm,
                                input lane_t imm, input vec_t vec_a, input vec_t vec_b);
      bus_if.req_op      = op;
      bus_if.req_use_imm = use_imm;
      bus_if.req_imm     = imm;
      bus_if.req_vec_a   = vec_a;
      bus_if.req_vec_b   = vec_b;
      bus_if.req_valid   = 1'b1;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: run did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst                = 1'b1;
      bus_if.req_valid   = 1'b0;
      bus_if.req_op      = '0;
      bus_if.req_use_imm = 1'b0;
      bus_if.req_imm     = '0;
      bus_if.req_vec_a   = '0;
      bus_if.req_vec_b   = '0;
      bus_if.rsp_ready   = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (5) step();

      $display("[TB] reset and idle");
      checkOutput("rst_req_ready", bus_if.req_ready, 1);
      checkOutput("rst_rsp_valid", bus_if.rsp_valid, 0);
      checkOutput("rst_busy", bus_if.busy, 0);
      checkOutput("rst_mux_sel", bus_if.alu_mux_sel, 0);
      checkOutput("rst_alu_a", bus_if.alu_a, 0);
      checkOutput("rst_alu_b_reg", bus_if.alu_b_reg, 0);
      checkOutput("rst_alu_imm", bus_if.alu_imm, 0);
      checkOutput("rst_alu_op", bus_if.alu_op, 0);
      checkOutput("rst_rsp_vec", bus_if.rsp_vec, 0);

      $display("[TB] register mode ADD");
      applyStimulus(ALU_ADD, 1'b0, 16'h0000, VEC_A_RAMP, VEC_B_0010);
      step();
      bus_if.req_valid = 1'b0;
      checkOutput("t2_req_ready_low", bus_if.req_ready, 0);
      checkOutput("t2_busy", bus_if.busy, 1);
      for (int i = 0; i < LANES; i++) begin
         checkOutput("t2_mux_sel", bus_if.alu_mux_sel, 0);
         checkOutput("t2_alu_a", bus_if.alu_a, 16'(i + 1));
         checkOutput("t2_alu_b_reg", bus_if.alu_b_reg, 16'h0010);
         checkOutput("t2_rsp_valid_early", bus_if.rsp_valid, 0);
         step();
      end
      checkOutput("t2_rsp_valid", bus_if.rsp_valid, 1);
      checkOutput("t2_rsp_vec", bus_if.rsp_vec, RSP_T2);
      checkOutput("t2_done_mux_sel", bus_if.alu_mux_sel, 0);
      bus_if.rsp_ready = 1'b1;
      step();
      bus_if.rsp_ready = 1'b0;
      checkOutput("t2_rsp_valid_fall", bus_if.rsp_valid, 0);
      checkOutput("t2_idle_ready", bus_if.req_ready, 1);
      checkOutput("t2_idle_rsp_held", bus_if.rsp_vec, RSP_T2);

      $display("[TB] immediate mode XOR");
      applyStimulus(ALU_XOR, 1'b1, 16'h00FF, {8{16'hAAAA}}, {8{16'h1234}});
      checkOutput("t3_idle_imm", bus_if.alu_imm, 0);
      checkOutput("t3_idle_mux_sel", bus_if.alu_mux_sel, 0);
      step();
      bus_if.req_valid = 1'b0;
      for (int i = 0; i < LANES; i++) begin
         checkOutput("t3_mux_sel", bus_if.alu_mux_sel, 1);
         checkOutput("t3_alu_imm", bus_if.alu_imm, 16'h00FF);
         checkOutput("t3_alu_op", bus_if.alu_op, ALU_XOR);
         step();
      end
      checkOutput("t3_rsp_vec", bus_if.rsp_vec, {8{16'hAA55}});
      checkOutput("t3_done_mux_sel", bus_if.alu_mux_sel, 0);
      checkOutput("t3_done_imm", bus_if.alu_imm, 0);
      checkOutput("t3_done_op", bus_if.alu_op, 0);
      checkOutput("t3_done_alu_a", bus_if.alu_a, 0);
      bus_if.rsp_ready = 1'b1;
      step();
      bus_if.rsp_ready = 1'b0;

      $display("[TB] backpressure and held second request");
      applyStimulus(ALU_ADD, 1'b0, 16'h0000, VEC_A_4, {8{16'h0001}});
      step();
      applyStimulus(ALU_SUB, 1'b1, 16'h0001, VEC_A_4B, {8{16'hFFFF}});
      checkOutput("t4_alu_a_latched", bus_if.alu_a, 16'h0100);
      repeat (LANES) step();
      for (int k = 0; k < 10; k++) begin
         checkOutput("t4_hold_valid", bus_if.rsp_valid, 1);
         checkOutput("t4_hold_vec", bus_if.rsp_vec, RSP_T4);
         checkOutput("t4_hold_ready", bus_if.req_ready, 0);
         step();
      end
      bus_if.rsp_ready = 1'b1;
      step();
      bus_if.rsp_ready = 1'b0;
      checkOutput("t4_no_bypass_valid", bus_if.rsp_valid, 0);
      checkOutput("t4_no_bypass_busy", bus_if.busy, 0);
      checkOutput("t4_no_bypass_ready", bus_if.req_ready, 1);
      step();
      bus_if.req_valid = 1'b0;
      checkOutput("t4_second_busy", bus_if.busy, 1);
      checkOutput("t4_second_alu_a", bus_if.alu_a, 16'h0010);
      checkOutput("t4_second_mux_sel", bus_if.alu_mux_sel, 1);
      checkOutput("t4_second_op", bus_if.alu_op, ALU_SUB);
      repeat (LANES) step();
      checkOutput("t4_second_valid", bus_if.rsp_valid, 1);
      checkOutput("t4_second_vec", bus_if.rsp_vec, RSP_T4B);
      bus_if.rsp_ready = 1'b1;
      step();
      bus_if.rsp_ready = 1'b0;

      $display("[TB] reset during RUN");
      applyStimulus(ALU_ADD, 1'b0, 16'h0000, VEC_A_RAMP, VEC_B_0010);
      step();
      bus_if.req_valid = 1'b0;
      repeat (3) step();
      checkOutput("t5_lane3_alu_a", bus_if.alu_a, 16'h0004);
      rst = 1'b1;
      #1;
      checkOutput("t5_async_ready", bus_if.req_ready, 1);
      checkOutput("t5_async_valid", bus_if.rsp_valid, 0);
      checkOutput("t5_async_busy", bus_if.busy, 0);
      checkOutput("t5_async_rsp_vec", bus_if.rsp_vec, 0);
      checkOutput("t5_async_alu_a", bus_if.alu_a, 0);
      #1 rst = 1'b0;
      step();
      checkOutput("t5_next_ready", bus_if.req_ready, 1);
      checkOutput("t5_next_busy", bus_if.busy, 0);

      $display("[TB] request inputs scrambled during RUN");
      bus_if.rsp_ready = 1'b1;
      step();
      checkOutput("t6_idle_rsp_ready_ignored", bus_if.req_ready, 1);
      applyStimulus(ALU_ADD, 1'b0, 16'h0000, VEC_A_6, {8{16'h0101}});
      step();
      for (int i = 0; i < LANES; i++) begin
         checkOutput("t6_alu_a", bus_if.alu_a, 16'(i * 16'h1000));
         checkOutput("t6_alu_op", bus_if.alu_op, ALU_ADD);
         checkOutput("t6_mux_sel", bus_if.alu_mux_sel, 0);
         bus_if.req_valid   = 1'($urandom);
         bus_if.req_op      = 4'($urandom);
         bus_if.req_use_imm = 1'($urandom);
         bus_if.req_imm     = 16'($urandom);
         bus_if.req_vec_a   = {$urandom, $urandom, $urandom, $urandom};
         bus_if.req_vec_b   = {$urandom, $urandom, $urandom, $urandom};
         step();
      end
      bus_if.rsp_ready = 1'b0;
      bus_if.req_valid = 1'b0;
      checkOutput("t6_rsp_valid", bus_if.rsp_valid, 1);
      checkOutput("t6_rsp_vec", bus_if.rsp_vec, RSP_T6);
      bus_if.rsp_ready = 1'b1;
      step();
      bus_if.rsp_ready = 1'b0;
      checkOutput("t6_rsp_valid_fall", bus_if.rsp_valid, 0);

      $display("CHECKS %0d ERRORS %0d", check_count, error_count);
      $finish;
   end

endmodule
